// File: rtl/stream_serialize8.sv
// Eight-lane to one-lane token serializer: collects one token per lane a..h and
// re-emits each frame in lane order, with end-of-stream frame handling.
module stream_serialize8 #(
  parameter int WIDTH = 9,
  parameter int CNTW  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_d,
  input  logic [WIDTH-1:0] b_d,
  input  logic [WIDTH-1:0] c_d,
  input  logic [WIDTH-1:0] d_d,
  input  logic [WIDTH-1:0] e_d,
  input  logic [WIDTH-1:0] f_d,
  input  logic [WIDTH-1:0] g_d,
  input  logic [WIDTH-1:0] h_d,
  input  logic             a_e,
  input  logic             b_e,
  input  logic             c_e,
  input  logic             d_e,
  input  logic             e_e,
  input  logic             f_e,
  input  logic             g_e,
  input  logic             h_e,
  input  logic             a_v,
  input  logic             b_v,
  input  logic             c_v,
  input  logic             d_v,
  input  logic             e_v,
  input  logic             f_v,
  input  logic             g_v,
  input  logic             h_v,
  output logic             a_b,
  output logic             b_b,
  output logic             c_b,
  output logic             d_b,
  output logic             e_b,
  output logic             f_b,
  output logic             g_b,
  output logic             h_b,
  output logic [WIDTH-1:0] o_d,
  output logic             o_e,
  output logic             o_v,
  input  logic             o_b,
  output logic             err,
  output logic [CNTW-1:0]  frame_cnt
);

  typedef enum logic {RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] lane_d [8];
  logic [7:0]       lane_e;
  logic [7:0]       lane_v;
  logic [7:0]       lane_b;
  logic [7:0]       take;

  logic [WIDTH-1:0] hold_d [8];
  logic [7:0]       hold_e;
  logic [7:0]       full;
  logic [7:0]       clr;
  logic [2:0]       ptr;

  logic             out_free;
  logic             eos_head;
  logic             frame_bad;
  logic             load_data;
  logic             load_eos;

  assign lane_d[0] = a_d;
  assign lane_d[1] = b_d;
  assign lane_d[2] = c_d;
  assign lane_d[3] = d_d;
  assign lane_d[4] = e_d;
  assign lane_d[5] = f_d;
  assign lane_d[6] = g_d;
  assign lane_d[7] = h_d;

  assign lane_e = {h_e, g_e, f_e, e_e, d_e, c_e, b_e, a_e};
  assign lane_v = {h_v, g_v, f_v, e_v, d_v, c_v, b_v, a_v};
  assign {h_b, g_b, f_b, e_b, d_b, c_b, b_b, a_b} = lane_b;

  assign lane_b = full | {8{state == DONE}};
  assign take   = lane_v & ~lane_b;

  assign out_free  = !o_v || !o_b;
  assign eos_head  = (ptr == 3'd0) && full[0] && hold_e[0];
  assign frame_bad = |(~hold_e[7:1]);

  // An EOS frame only fires once every lane holds its token, so the whole
  // frame is consumed in one step and no stray lane leaks into the next frame.
  always_comb begin
    state_next = state;
    load_data  = 1'b0;
    load_eos   = 1'b0;
    if (state == RUN && out_free) begin
      if (eos_head) begin
        if (&full) begin
          load_eos   = 1'b1;
          state_next = DONE;
        end
      end else if (full[ptr]) begin
        load_data = 1'b1;
      end
    end
  end

  always_comb begin
    clr = 8'h00;
    if (load_eos)
      clr = 8'hFF;
    else if (load_data)
      clr = 8'b1 << ptr;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= RUN;
    else
      state <= state_next;
  end

  // Lane holding registers: data is only meaningful while its full flag is set.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 8; i++) begin
      if (take[i]) begin
        hold_d[i] <= lane_d[i];
        hold_e[i] <= lane_e[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full      <= 8'h00;
      ptr       <= 3'd0;
      err       <= 1'b0;
      frame_cnt <= '0;
      o_v       <= 1'b0;
      o_e       <= 1'b0;
      o_d       <= '0;
    end else begin
      full <= (full & ~clr) | take;
      // Output register stage
      if (load_eos) begin
        o_v <= 1'b1;
        o_e <= 1'b1;
        o_d <= '0;
        if (frame_bad)
          err <= 1'b1;
      end else if (load_data) begin
        o_v <= 1'b1;
        o_e <= 1'b0;
        o_d <= hold_d[ptr];
        ptr <= ptr + 3'd1;
        if (ptr == 3'd7)
          frame_cnt <= frame_cnt + CNTW'(1);
        if (ptr != 3'd0 && hold_e[ptr])
          err <= 1'b1;
      end else if (out_free) begin
        o_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_serialize8.sv
// Directed bench for stream_serialize8: queue-based frame model checked on every
// accepted output token, plus literal expectations for each scenario.
module tb_stream_serialize8;
  localparam int WIDTH = 9;
  localparam int CNTW  = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] dv [8];
  logic [7:0]       ev;
  logic [7:0]       vv;
  logic [7:0]       bv;
  logic [WIDTH-1:0] o_d;
  logic             o_e;
  logic             o_v;
  logic             o_b;
  logic             err;
  logic [CNTW-1:0]  frame_cnt;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [WIDTH:0] prod_q [8][$];
  logic [WIDTH:0] lane_q [8][$];
  logic [WIDTH:0] log_q [$];
  int             log_cyc [$];
  int             xfer_cyc_a;

  int             m_ptr;
  logic           m_err;
  logic [CNTW-1:0] m_cnt;
  logic           held;
  logic [WIDTH-1:0] held_d;
  logic           held_e;

  stream_serialize8 #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clock(clock), .reset(reset),
    .a_d(dv[0]), .b_d(dv[1]), .c_d(dv[2]), .d_d(dv[3]),
    .e_d(dv[4]), .f_d(dv[5]), .g_d(dv[6]), .h_d(dv[7]),
    .a_e(ev[0]), .b_e(ev[1]), .c_e(ev[2]), .d_e(ev[3]),
    .e_e(ev[4]), .f_e(ev[5]), .g_e(ev[6]), .h_e(ev[7]),
    .a_v(vv[0]), .b_v(vv[1]), .c_v(vv[2]), .d_v(vv[3]),
    .e_v(vv[4]), .f_v(vv[5]), .g_v(vv[6]), .h_v(vv[7]),
    .a_b(bv[0]), .b_b(bv[1]), .c_b(bv[2]), .d_b(bv[3]),
    .e_b(bv[4]), .f_b(bv[5]), .g_b(bv[6]), .h_b(bv[7]),
    .o_d(o_d), .o_e(o_e), .o_v(o_v), .o_b(o_b),
    .err(err), .frame_cnt(frame_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Producers: each lane presents the head of its queue and holds it until accepted.
  always @(posedge clock) begin
    for (int i = 0; i < 8; i++)
      if (reset && vv[i] && !bv[i] && prod_q[i].size() > 0)
        void'(prod_q[i].pop_front());
    #1;
    for (int i = 0; i < 8; i++) begin
      if (prod_q[i].size() > 0) begin
        vv[i] = 1'b1;
        ev[i] = prod_q[i][0][WIDTH];
        dv[i] = prod_q[i][0][WIDTH-1:0];
      end else begin
        vv[i] = 1'b0;
      end
    end
  end

  // Model and compare: expected stream is built from accepted tokens, frame by frame in lane order.
  always @(negedge clock) begin
    logic [WIDTH:0]   tok;
    logic [WIDTH-1:0] exp_d;
    logic             exp_e;
    cyc++;
    if (!reset) begin
      for (int i = 0; i < 8; i++) lane_q[i].delete();
      m_ptr = 0;
      m_err = 1'b0;
      m_cnt = '0;
      held  = 1'b0;
    end else begin
      if (held) begin
        check("hold_v", 32'(o_v), 32'd1);
        check("hold_d", 32'(o_d), 32'(held_d));
        check("hold_e", 32'(o_e), 32'(held_e));
      end
      held   = o_v && o_b;
      held_d = o_d;
      held_e = o_e;
      if (o_v && !o_b) begin
        if (m_ptr == 0 && lane_q[0].size() > 0 && lane_q[0][0][WIDTH]) begin
          exp_d = '0;
          exp_e = 1'b1;
          for (int i = 0; i < 8; i++) begin
            if (lane_q[i].size() == 0) begin
              check("model_eos_lane", 32'(i), 32'hFFFF);
            end else begin
              tok = lane_q[i].pop_front();
              if (i != 0 && !tok[WIDTH]) m_err = 1'b1;
            end
          end
        end else if (lane_q[m_ptr].size() == 0) begin
          exp_d = '0;
          exp_e = 1'b0;
          check("unexpected_token", 32'(o_d), 32'hFFFF);
        end else begin
          tok   = lane_q[m_ptr].pop_front();
          exp_d = tok[WIDTH-1:0];
          exp_e = 1'b0;
          if (m_ptr != 0 && tok[WIDTH]) m_err = 1'b1;
          if (m_ptr == 7) m_cnt = m_cnt + 1'b1;
          m_ptr = (m_ptr + 1) % 8;
        end
        check("o_d", 32'(o_d), 32'(exp_d));
        check("o_e", 32'(o_e), 32'(exp_e));
        check("err", 32'(err), 32'(m_err));
        check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        log_q.push_back({o_e, o_d});
        log_cyc.push_back(cyc);
      end
      for (int i = 0; i < 8; i++) begin
        if (vv[i] && !bv[i]) begin
          lane_q[i].push_back({ev[i], dv[i]});
          if (i == 0) xfer_cyc_a = cyc;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] base, input logic [7:0] eos);
    for (int l = 0; l < 8; l++)
      prod_q[l].push_back({eos[l], base + WIDTH'(l)});
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  task automatic reset_check(input string tag);
    @(negedge clock);
    #1;
    check({tag, "_o_v"}, 32'(o_v), 32'd0);
    check({tag, "_o_e"}, 32'(o_e), 32'd0);
    check({tag, "_o_d"}, 32'(o_d), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, "_b"}, 32'(bv), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) prod_q[i].delete();
    clear_log();
    tick(1);
    reset_check(tag);
    tick(1);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [9:0] exp_tok;
    reset = 1'b0;
    vv    = 8'h00;
    ev    = 8'h00;
    o_b   = 1'b0;
    for (int i = 0; i < 8; i++) dv[i] = '0;
    tick(2);
    reset_check("por");
    tick(1);
    reset = 1'b1;
    tick(2);

    // Single frame 1..8
    clear_log();
    push_frame(9'h001, 8'h00);
    wait_log(8, 40, "t1_timeout");
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      exp_tok = 10'(i + 1);
      check("t1_tok", 32'(log_q[i]), 32'(exp_tok));
    end
    if (log_q.size() >= 8) begin
      check("t1_latency", 32'(log_cyc[0] - xfer_cyc_a), 32'd2);
      check("t1_consec", 32'(log_cyc[7] - log_cyc[0]), 32'd7);
    end
    tick(2);
    check("t1_cnt", 32'(frame_cnt), 32'd1);
    check("t1_idle", 32'(o_v), 32'd0);

    // Out-of-order arrival, h first
    clear_log();
    for (int l = 7; l >= 0; l--) begin
      if (l == 3) begin
        check("t2_h_b", 32'(bv[7]), 32'd1);
        check("t2_no_out", 32'(o_v), 32'd0);
      end
      prod_q[l].push_back({1'b0, 9'h0A0 + 9'(l)});
      tick(1);
    end
    wait_log(8, 40, "t2_timeout");
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      exp_tok = 10'h0A0 + 10'(i);
      check("t2_tok", 32'(log_q[i]), 32'(exp_tok));
    end
    tick(2);
    check("t2_b_clear", 32'(bv), 32'd0);
    check("t2_cnt", 32'(frame_cnt), 32'd2);

    // Downstream backpressure on the first token
    clear_log();
    o_b = 1'b1;
    push_frame(9'h001, 8'h00);
    k = 0;
    while (!o_v && k < 20) begin tick(1); k++; end
    check("t3_first_out", 32'(o_v), 32'd1);
    tick(3);
    check("t3_hold_d", 32'(o_d), 32'd1);
    check("t3_hold_v", 32'(o_v), 32'd1);
    tick(2);
    o_b = 1'b0;
    wait_log(8, 40, "t3_timeout");
    tick(4);
    check("t3_count", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      exp_tok = 10'(i + 1);
      check("t3_tok", 32'(log_q[i]), 32'(exp_tok));
    end

    // Three back-to-back frames
    clear_log();
    for (int f = 0; f < 3; f++) push_frame(9'h030 + 9'(8 * f), 8'h00);
    wait_log(24, 80, "t4_timeout");
    if (log_q.size() >= 24) begin
      check("t4_consec", 32'(log_cyc[23] - log_cyc[0]), 32'd23);
      exp_tok = 10'h047;
      check("t4_last", 32'(log_q[23]), 32'(exp_tok));
    end
    tick(2);
    check("t4_cnt", 32'(frame_cnt), 32'd6);

    // Clean EOS frame
    clear_log();
    push_frame(9'h055, 8'hFF);
    wait_log(1, 40, "t5_timeout");
    tick(3);
    check("t5_tok", 32'(log_q.size() > 0 ? log_q[0] : 10'h3FF), 32'h200);
    check("t5_b", 32'(bv), 32'hFF);
    check("t5_o_v", 32'(o_v), 32'd0);
    check("t5_err", 32'(err), 32'd0);
    push_frame(9'h011, 8'h00);
    tick(12);
    check("t5_done_count", 32'(log_q.size()), 32'd1);
    check("t5_done_o_v", 32'(o_v), 32'd0);
    check("t5_cnt", 32'(frame_cnt), 32'd6);

    // EOS frame with lane d not flagged
    do_reset("r1");
    clear_log();
    push_frame(9'h055, 8'hF7);
    wait_log(1, 40, "t6_timeout");
    tick(3);
    check("t6_tok", 32'(log_q.size() > 0 ? log_q[0] : 10'h3FF), 32'h200);
    check("t6_err", 32'(err), 32'd1);
    check("t6_b", 32'(bv), 32'hFF);

    // Reset after three tokens of a frame, then a fresh frame
    do_reset("r2");
    clear_log();
    push_frame(9'h0E1, 8'h00);
    wait_log(3, 40, "t7_partial_timeout");
    do_reset("r3");
    push_frame(9'h101, 8'h00);
    wait_log(8, 40, "t7_timeout");
    tick(6);
    check("t7_count", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      exp_tok = 10'h101 + 10'(i);
      check("t7_tok", 32'(log_q[i]), 32'(exp_tok));
    end
    check("t7_cnt", 32'(frame_cnt), 32'd1);
    check("t7_err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
